lc3b_fwd_hazard_unit: RTL and testbench

Parametrised forwarding and load-use interlock unit for the pipelined LC-3b datapath. Sits beside the EX stage. For each EX-stage source operand it selects the nearest in-flight producer among NUM_FWD later stages. It stalls EX while a load in MEM has not yet returned the data EX needs, and watches that stall with a timeout.

---
 rtl/lc3b_fwd_hazard_unit.sv | 97 +++++++++
 tb/tb_lc3b_fwd_hazard_unit.sv | 130 +++++++++++++
 2 files changed

// File: rtl/lc3b_fwd_hazard_unit.sv
// rtl/lc3b_fwd_hazard_unit.sv - EX-stage operand forwarding and load-use interlock with stall watchdog
// Optional macro FWD_PERF_EN adds the stall_cycles performance counter output.
module lc3b_fwd_hazard_unit #(
  parameter int NUM_SRC = 2,
  parameter int NUM_FWD = 2,
  parameter int REG_W   = 3,
  parameter int TIMEOUT = 64,
  parameter int SEL_W   = $clog2(NUM_FWD + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_SRC*REG_W-1:0]   ex_src,
  input  logic [NUM_SRC-1:0]         ex_src_used,
  input  logic [NUM_FWD-1:0]         fwd_reg_write,
  input  logic [NUM_FWD*REG_W-1:0]   fwd_dest,
  input  logic                       mem_is_load,
  input  logic                       mem_resp,
  input  logic                       flush,
  output logic [NUM_SRC*SEL_W-1:0]   fwd_sel,
  output logic                       stall_ex,
  output logic                       hazard_err
`ifdef FWD_PERF_EN
  ,output logic [15:0]               stall_cycles
`endif
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  typedef enum logic {IDLE, LOAD_WAIT} state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  wait_cnt;
  logic              stage0_match;
  logic              load_hit;

  // Descending scan so the nearest (lowest-index) matching stage wins.
  always_comb begin
    fwd_sel      = '0;
    stage0_match = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = NUM_FWD - 1; k >= 0; k--) begin
        if (ex_src_used[i] && fwd_reg_write[k] &&
            fwd_dest[k*REG_W +: REG_W] == ex_src[i*REG_W +: REG_W]) begin
          fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k + 1);
          if (k == 0) stage0_match = 1'b1;
        end
      end
    end
  end

  assign load_hit = mem_is_load && fwd_reg_write[0] && stage0_match;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (load_hit && !mem_resp && !flush) state_next = LOAD_WAIT;
      LOAD_WAIT: if (flush || mem_resp)               state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Stall is purely a function of the current inputs; the FSM only feeds the watchdog.
  always_comb begin
    stall_ex = load_hit && !mem_resp && !flush;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt   <= '0;
      hazard_err <= 1'b0;
    end else begin
      if (state == LOAD_WAIT && state_next == LOAD_WAIT) begin
        if (wait_cnt != CNT_MAX) wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end
      if (state == LOAD_WAIT && wait_cnt == CNT_MAX && stall_ex)
        hazard_err <= 1'b1;
    end
  end

`ifdef FWD_PERF_EN
  always_ff @(posedge clk) begin
    if (rst)
      stall_cycles <= '0;
    else if (stall_ex && stall_cycles != 16'hFFFF)
      stall_cycles <= stall_cycles + 16'd1;
  end
`endif

endmodule

// File: tb/tb_lc3b_fwd_hazard_unit.sv
// tb/tb_lc3b_fwd_hazard_unit.sv - scoreboard bench for lc3b_fwd_hazard_unit (TIMEOUT=4)
module tb_lc3b_fwd_hazard_unit;

  logic       clk;
  logic       rst;
  logic [5:0] ex_src;
  logic [1:0] ex_src_used;
  logic [1:0] fwd_reg_write;
  logic [5:0] fwd_dest;
  logic       mem_is_load;
  logic       mem_resp;
  logic       flush;
  logic [3:0] fwd_sel;
  logic       stall_ex;
  logic       hazard_err;
`ifdef FWD_PERF_EN
  logic [15:0] stall_cycles;
`endif

  lc3b_fwd_hazard_unit #(.NUM_SRC(2), .NUM_FWD(2), .REG_W(3), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .ex_src(ex_src), .ex_src_used(ex_src_used),
    .fwd_reg_write(fwd_reg_write), .fwd_dest(fwd_dest), .mem_is_load(mem_is_load),
    .mem_resp(mem_resp), .flush(flush), .fwd_sel(fwd_sel), .stall_ex(stall_ex),
    .hazard_err(hazard_err)
`ifdef FWD_PERF_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  typedef struct packed {
    logic [3:0]  sel;
    logic        stall;
    logic        err;
    logic [15:0] perf;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_fails  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input string what, input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("FAIL %s.%s: got %0h expected %0h", nm, what, act, req);
    end
  endtask

  // Monitor: inputs are driven 1ns after posedge, outputs sampled at the following negedge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      chk(nm, "fwd_sel",    {12'd0, fwd_sel},    {12'd0, e.sel});
      chk(nm, "stall_ex",   {15'd0, stall_ex},   {15'd0, e.stall});
      chk(nm, "hazard_err", {15'd0, hazard_err}, {15'd0, e.err});
`ifdef FWD_PERF_EN
      chk(nm, "stall_cycles", stall_cycles, e.perf);
`endif
    end
  end

  task automatic apply(input logic r, input logic [2:0] s0, input logic [2:0] s1,
                       input logic [1:0] used, input logic [1:0] wr,
                       input logic [2:0] d0, input logic [2:0] d1,
                       input logic ld, input logic resp, input logic fl,
                       input logic [1:0] e0, input logic [1:0] e1,
                       input logic est, input logic eerr, input logic [15:0] eperf,
                       input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; ex_src = {s1, s0}; ex_src_used = used; fwd_reg_write = wr;
    fwd_dest = {d1, d0}; mem_is_load = ld; mem_resp = resp; flush = fl;
    e.sel = {e1, e0}; e.stall = est; e.err = eerr; e.perf = eperf;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  initial begin
    rst = 1'b1; ex_src = '0; ex_src_used = '0; fwd_reg_write = '0;
    fwd_dest = '0; mem_is_load = 1'b0; mem_resp = 1'b0; flush = 1'b0;

    //     rst s0 s1 used   wr     d0 d1 ld rp fl e0 e1 st er perf
    apply(1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'd0,  "reset");
    apply(0, 3, 0, 2'b01, 2'b11, 3, 3, 0, 0, 0, 1, 0, 0, 0, 16'd0,  "nearest_wins");
    apply(0, 3, 0, 2'b01, 2'b10, 0, 3, 0, 0, 0, 2, 0, 0, 0, 16'd0,  "stage1_only");
    apply(0, 2, 6, 2'b01, 2'b11, 1, 6, 0, 0, 0, 0, 0, 0, 0, 16'd0,  "src1_unused");
    apply(0, 2, 6, 2'b11, 2'b11, 1, 6, 0, 0, 0, 0, 2, 0, 0, 16'd0,  "src1_used");
    apply(0, 4, 0, 2'b01, 2'b00, 4, 4, 0, 0, 0, 0, 0, 0, 0, 16'd0,  "no_write");
    apply(0, 0, 5, 2'b10, 2'b01, 5, 0, 1, 0, 0, 0, 1, 1, 0, 16'd0,  "ld_stall1");
    apply(0, 0, 5, 2'b10, 2'b01, 5, 0, 1, 0, 0, 0, 1, 1, 0, 16'd1,  "ld_stall2");
    apply(0, 0, 5, 2'b10, 2'b01, 5, 0, 1, 0, 0, 0, 1, 1, 0, 16'd2,  "ld_stall3");
    apply(0, 0, 5, 2'b10, 2'b01, 5, 0, 1, 1, 0, 0, 1, 0, 0, 16'd3,  "ld_resp");
    apply(0, 0, 5, 2'b10, 2'b01, 5, 0, 1, 1, 0, 0, 1, 0, 0, 16'd3,  "hit_with_resp");
    apply(0, 0, 5, 2'b10, 2'b01, 5, 0, 0, 0, 0, 0, 1, 0, 0, 16'd3,  "no_load_fwd");
    apply(0, 0, 5, 2'b10, 2'b01, 5, 0, 1, 0, 0, 0, 1, 1, 0, 16'd3,  "fl_stall1");
    apply(0, 0, 5, 2'b10, 2'b01, 5, 0, 1, 0, 0, 0, 1, 1, 0, 16'd4,  "fl_stall2");
    apply(0, 0, 5, 2'b10, 2'b01, 5, 0, 1, 0, 1, 0, 1, 0, 0, 16'd5,  "flush");
    apply(0, 0, 5, 2'b10, 2'b01, 5, 0, 1, 1, 1, 0, 1, 0, 0, 16'd5,  "flush_resp");
    apply(0, 0, 5, 2'b10, 2'b01, 5, 0, 1, 0, 0, 0, 1, 1, 0, 16'd5,  "to_idle");
    apply(0, 0, 5, 2'b10, 2'b01, 5, 0, 1, 0, 0, 0, 1, 1, 0, 16'd6,  "to_wc0");
    apply(0, 0, 5, 2'b10, 2'b01, 5, 0, 1, 0, 0, 0, 1, 1, 0, 16'd7,  "to_wc1");
    apply(0, 0, 5, 2'b10, 2'b01, 5, 0, 1, 0, 0, 0, 1, 1, 0, 16'd8,  "to_wc2");
    apply(0, 0, 5, 2'b10, 2'b01, 5, 0, 1, 0, 0, 0, 1, 1, 0, 16'd9,  "to_wc3");
    apply(0, 0, 5, 2'b10, 2'b01, 5, 0, 1, 0, 0, 0, 1, 1, 1, 16'd10, "to_err_set");
    apply(0, 0, 5, 2'b10, 2'b01, 5, 0, 1, 1, 0, 0, 1, 0, 1, 16'd11, "to_resp_sticky");
    apply(0, 0, 5, 2'b10, 2'b01, 5, 0, 0, 0, 0, 0, 1, 0, 1, 16'd11, "to_idle_sticky");
    apply(1, 0, 5, 2'b10, 2'b01, 5, 0, 1, 0, 0, 0, 1, 1, 1, 16'd11, "rst_ungated");
    apply(0, 0, 5, 2'b10, 2'b01, 5, 0, 0, 0, 0, 0, 1, 0, 0, 16'd0,  "post_rst");
    apply(0, 0, 5, 2'b10, 2'b01, 5, 0, 1, 0, 0, 0, 1, 1, 0, 16'd0,  "re_stall");
    apply(0, 0, 5, 2'b10, 2'b01, 5, 0, 1, 1, 0, 0, 1, 0, 0, 16'd1,  "re_resp");

    for (int c = 0; c < 20 && exp_q.size() > 0; c++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fails++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
